// File: rtl/hex_keypad_scanner.sv
// 4x4 hex keypad scanner: drives one column low per slot and debounces whole frames.
// Each accepted key is shifted into a 16-bit entry word with the newest digit in [3:0].
module hex_keypad_scanner #(
  parameter int SCAN_TICKS     = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [15:0] data
);

  localparam int TW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam int CW = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS + 1) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);
  localparam logic [CW-1:0] CNT_DB    = CW'(DEBOUNCE_SCANS);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO  = '0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    HELD    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    FR_NONE   = 2'd0,
    FR_SINGLE = 2'd1,
    FR_MULTI  = 2'd2
  } frame_t;

  logic [3:0]      row_meta;
  logic [3:0]      row_sync;
  logic [TW-1:0]   tick;
  logic [1:0]      col_idx;
  logic [1:0]      col_idx_next;
  logic [2:0][3:0] frame_buf;
  logic            slot_end;
  logic            frame_end;

  logic [15:0]     hits;
  logic [1:0]      hit_cnt;
  logic [3:0]      fr_code;
  frame_t          fr_kind;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [3:0]      cand, cand_n;
  logic            accept;

  assign slot_end     = (tick == TICK_LAST);
  assign frame_end    = slot_end && (col_idx == 2'd3);
  assign col_idx_next = col_idx + 2'd1;

  // Column 3 is never buffered: its sample is consumed live on the frame-end edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta  <= 4'hF;
      row_sync  <= 4'hF;
      tick      <= '0;
      col_idx   <= 2'd0;
      col       <= 4'b1110;
      frame_buf <= '1;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
      if (slot_end) begin
        tick    <= '0;
        col_idx <= col_idx_next;
        col     <= ~(4'b0001 << col_idx_next);
        case (col_idx)
          2'd0:    frame_buf[0] <= row_sync;
          2'd1:    frame_buf[1] <= row_sync;
          2'd2:    frame_buf[2] <= row_sync;
          default: ;
        endcase
      end else begin
        tick <= tick + TW'(1);
      end
    end
  end

  // hits bit index equals the key code {row_idx, col_idx}.
  always_comb begin
    hits = '0;
    for (int c = 0; c < 3; c++) begin
      for (int r = 0; r < 4; r++) begin
        hits[r*4 + c] = ~frame_buf[c][r];
      end
    end
    for (int r = 0; r < 4; r++) begin
      hits[r*4 + 3] = ~row_sync[r];
    end
  end

  always_comb begin
    hit_cnt = 2'd0;
    fr_code = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (hits[i]) begin
        if (hit_cnt == 2'd0) begin
          fr_code = 4'(i);
        end
        if (hit_cnt != 2'd2) begin
          hit_cnt = hit_cnt + 2'd1;
        end
      end
    end
  end

  always_comb begin
    case (hit_cnt)
      2'd0:    fr_kind = FR_NONE;
      2'd1:    fr_kind = FR_SINGLE;
      default: fr_kind = FR_MULTI;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= CNT_ZERO;
      cand  <= 4'd0;
    end else if (frame_end) begin
      state <= state_n;
      cnt   <= cnt_n;
      cand  <= cand_n;
    end
  end

  // Evaluated only on frame_end; a single-frame threshold skips PRESS/RELEASE entirely.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cand_n  = cand;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        if (fr_kind == FR_SINGLE) begin
          cand_n = fr_code;
          if (CNT_ONE >= CNT_DB) begin
            state_n = HELD;
            cnt_n   = CNT_ZERO;
            accept  = 1'b1;
          end else begin
            state_n = PRESS;
            cnt_n   = CNT_ONE;
          end
        end
      end
      PRESS: begin
        if (fr_kind == FR_SINGLE && fr_code == cand) begin
          if (cnt + CNT_ONE >= CNT_DB) begin
            state_n = HELD;
            cnt_n   = CNT_ZERO;
            accept  = 1'b1;
          end else begin
            cnt_n = cnt + CNT_ONE;
          end
        end else if (fr_kind == FR_SINGLE) begin
          cand_n = fr_code;
          cnt_n  = CNT_ONE;
        end else begin
          state_n = IDLE;
          cnt_n   = CNT_ZERO;
        end
      end
      HELD: begin
        if (fr_kind == FR_NONE) begin
          if (CNT_ONE >= CNT_DB) begin
            state_n = IDLE;
            cnt_n   = CNT_ZERO;
          end else begin
            state_n = RELEASE;
            cnt_n   = CNT_ONE;
          end
        end
      end
      RELEASE: begin
        if (fr_kind == FR_NONE) begin
          if (cnt + CNT_ONE >= CNT_DB) begin
            state_n = IDLE;
            cnt_n   = CNT_ZERO;
          end else begin
            cnt_n = cnt + CNT_ONE;
          end
        end else begin
          state_n = HELD;
          cnt_n   = CNT_ZERO;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = CNT_ZERO;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_valid <= 1'b0;
      key_code  <= 4'd0;
      data      <= 16'd0;
    end else begin
      key_valid <= frame_end && accept;
      if (frame_end && accept) begin
        key_code <= cand_n;
        data     <= {data[11:0], cand_n};
      end
    end
  end

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// Bench for hex_keypad_scanner: keypad matrix model, frame-level debounce reference model,
// directed scenarios followed by randomized press/release sequences.
module tb_hex_keypad_scanner;

  localparam int ST = 4;
  localparam int DB = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] data;
  logic [15:0] keys;

  int total = 0;
  int bad = 0;
  int pulses = 0;
  int exp_pulses = 0;

  bit          armed;
  int          none_run;
  int          press_run;
  logic [3:0]  run_code;
  logic [15:0] exp_data;
  logic [3:0]  exp_code;

  hex_keypad_scanner #(.SCAN_TICKS(ST), .DEBOUNCE_SCANS(DB)) dut (
    .clk(clk), .rst(rst), .row(row), .col(col),
    .key_valid(key_valid), .key_code(key_code), .data(data)
  );

  always #5 clk = ~clk;

  // Passive matrix: a row reads low when any pressed key on it sits in a driven column.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4 + c] && (col[c] === 1'b0)) row[r] = 1'b0;
      end
    end
  end

  always @(negedge clk) if (key_valid === 1'b1) pulses++;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    armed     = 1'b1;
    none_run  = 0;
    press_run = 0;
    run_code  = 4'd0;
    exp_data  = 16'd0;
    exp_code  = 4'd0;
  endtask

  // Accept when DB consecutive frames show the same lone key, but only once per release:
  // re-arming needs DB consecutive empty frames.
  task automatic model_frame(input logic [15:0] mask, output bit pulse);
    int n;
    logic [3:0] code;
    pulse = 1'b0;
    n = $countones(mask);
    code = 4'd0;
    for (int i = 0; i < 16; i++) if (mask[i]) code = 4'(i);
    if (n == 0) begin
      press_run = 0;
      none_run++;
      if (none_run >= DB) armed = 1'b1;
    end else begin
      none_run = 0;
      if (n == 1) begin
        if (press_run > 0 && code == run_code) press_run++;
        else begin
          press_run = 1;
          run_code  = code;
        end
        if (armed && press_run >= DB) begin
          pulse    = 1'b1;
          armed    = 1'b0;
          exp_code = code;
          exp_data = {exp_data[11:0], code};
        end
      end else begin
        press_run = 0;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("rst_col", {12'd0, col}, 16'h000E);
    chk("rst_key_valid", {15'd0, key_valid}, 16'd0);
    chk("rst_key_code", {12'd0, key_code}, 16'd0);
    chk("rst_data", data, 16'd0);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic do_frame(input logic [15:0] mask);
    bit p;
    logic [3:0] exp_col;
    keys = mask;
    for (int j = 1; j <= 4*ST; j++) begin
      @(posedge clk);
      @(negedge clk);
      exp_col = ~(4'b0001 << ((j / ST) % 4));
      chk("col_walk", {12'd0, col}, {12'd0, exp_col});
      if (j < 4*ST) chk("key_valid_quiet", {15'd0, key_valid}, 16'd0);
    end
    model_frame(mask, p);
    if (p) exp_pulses++;
    chk("frame_key_valid", {15'd0, key_valid}, {15'd0, p});
    chk("frame_key_code", {12'd0, key_code}, {12'd0, exp_code});
    chk("frame_data", data, exp_data);
  endtask

  task automatic hold(input logic [15:0] mask, input int n);
    for (int i = 0; i < n; i++) do_frame(mask);
  endtask

  initial begin
    logic [15:0] m;
    int k1, k2, len;
    rst  = 1'b1;
    keys = 16'd0;
    model_reset();
    @(negedge clk);
    do_reset();
    hold(16'd0, 2);

    hold(16'h0040, 10);
    hold(16'd0, 3);
    chk("key6_code", {12'd0, key_code}, 16'h0006);
    chk("key6_data", data, 16'h0006);

    for (int k = 1; k <= 4; k++) begin
      m = 16'd1 << k;
      hold(m, 3);
      hold(16'd0, 3);
    end
    chk("seq_1234", data, 16'h1234);
    hold(16'h8000, 3);
    hold(16'd0, 3);
    chk("seq_234F", data, 16'h234F);

    for (int i = 0; i < 5; i++) begin
      do_frame(16'h0020);
      do_frame(16'd0);
    end
    chk("bounce_data", data, 16'h234F);
    hold(16'h0020, 3);
    hold(16'd0, 3);
    chk("bounce_code", {12'd0, key_code}, 16'h0005);
    chk("bounce_data2", data, 16'h34F5);

    hold(16'h0201, 6);
    chk("ghost_data", data, 16'h34F5);
    hold(16'h0001, 3);
    hold(16'd0, 3);
    chk("ghost_release", data, 16'h4F50);

    hold(16'h1000, 1);
    do_reset();
    hold(16'h1000, 3);
    chk("rst_redebounce", data, 16'h000C);
    hold(16'd0, 3);

    keys = 16'h0080;
    repeat (7) begin
      @(posedge clk);
      @(negedge clk);
    end
    do_reset();
    hold(16'h0080, 3);
    hold(16'd0, 3);
    chk("midframe_rst", data, 16'h0007);

    for (int s = 0; s < 40; s++) begin
      k1  = $urandom_range(0, 15);
      k2  = (k1 + $urandom_range(1, 15)) % 16;
      len = $urandom_range(1, 4);
      case ($urandom_range(0, 3))
        0:       m = 16'd0;
        3:       m = (16'd1 << k1) | (16'd1 << k2);
        default: m = 16'd1 << k1;
      endcase
      hold(m, len);
    end
    hold(16'd0, 3);
    chk("pulse_count", 16'(pulses), 16'(exp_pulses));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
